// File: rtl/ftc_dec_top.sv
// ftc_dec_top: forbidden-transition-code decoder, 44-bit coded bus to 32-bit data, 2-stage pipeline
// Ports: clk, rst (sync, active-low), data_in[43:0] (11 x 4-bit codewords), in_valid, err_clr,
//        data_out[31:0], out_valid, err, err_group[10:0] (per-group invalid), err_count[15:0] (saturating)
module ftc_dec_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [43:0] data_in,
    input  logic        in_valid,
    input  logic        err_clr,
    output logic [31:0] data_out,
    output logic        out_valid,
    output logic        err,
    output logic [10:0] err_group,
    output logic [15:0] err_count
);
    logic [43:0] cap_q;
    logic        s1_q;
    logic [31:0] dout_d;
    logic [10:0] grp_d;
    logic [3:0]  t;
    // Returns {invalid, value}; invalid codewords decode to 000
    function automatic logic [3:0] dec(input logic [3:0] c);
        case (c)
            4'b0000: dec = 4'b0000;
            4'b0001: dec = 4'b0001;
            4'b0011: dec = 4'b0010;
            4'b0111: dec = 4'b0011;
            4'b1000: dec = 4'b0100;
            4'b1001: dec = 4'b0101;
            4'b1100: dec = 4'b0110;
            4'b1111: dec = 4'b0111;
            default: dec = 4'b1000;
        endcase
    endfunction
    always_comb begin
        dout_d = '0;
        grp_d  = '0;
        t      = '0;
        for (int g = 0; g < 10; g++) begin
            t                = dec(cap_q[4*g +: 4]);
            dout_d[3*g +: 3] = t[2:0];
            grp_d[g]         = t[3];
        end
        // Top group only carries two bits, so any codeword with msb value set is invalid too
        t              = dec(cap_q[43:40]);
        grp_d[10]      = t[3] | t[2];
        dout_d[31:30]  = grp_d[10] ? 2'b00 : t[1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_q     <= '0;
            s1_q      <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_group <= '0;
            err_count <= '0;
        end else begin
            if (in_valid) cap_q <= data_in;
            s1_q      <= in_valid;
            out_valid <= s1_q;
            if (s1_q) begin
                data_out  <= dout_d;
                err_group <= grp_d;
                err       <= |grp_d;
            end
            if (err_clr) err_count <= '0;
            else if (s1_q && |grp_d && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_ftc_dec_top.sv
// tb_ftc_dec_top: directed self-checking bench for ftc_dec_top
module tb_ftc_dec_top;
    logic        clk = 1'b0;
    logic        rst;
    logic [43:0] data_in;
    logic        in_valid;
    logic        err_clr;
    logic [31:0] data_out;
    logic        out_valid;
    logic        err;
    logic [10:0] err_group;
    logic [15:0] err_count;
    int tests = 0;
    int fails = 0;
    localparam logic [43:0] BAD = 44'h800_0000_5000;
    ftc_dec_top dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .err_clr(err_clr),
        .data_out(data_out), .out_valid(out_valid), .err(err), .err_group(err_group),
        .err_count(err_count)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] cw(input logic [2:0] v);
        case (v)
            3'd0: cw = 4'b0000;
            3'd1: cw = 4'b0001;
            3'd2: cw = 4'b0011;
            3'd3: cw = 4'b0111;
            3'd4: cw = 4'b1000;
            3'd5: cw = 4'b1001;
            3'd6: cw = 4'b1100;
            default: cw = 4'b1111;
        endcase
    endfunction
    function automatic logic [43:0] enc(input logic [31:0] d);
        logic [43:0] r;
        for (int g = 0; g < 10; g++) r[4*g +: 4] = cw(d[3*g +: 3]);
        r[43:40] = cw({1'b0, d[31:30]});
        return r;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic ov, input logic [31:0] d, input logic e);
        chk({tag, "_ov"}, {63'd0, out_valid}, {63'd0, ov});
        chk({tag, "_data"}, {32'd0, data_out}, {32'd0, d});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, e});
    endtask
    initial begin
        rst = 1'b0; in_valid = 1'b1; err_clr = 1'b0; data_in = {12'($urandom), $urandom};
        step();
        chk("rst0_all", {out_valid, err, err_group, err_count, data_out}, 64'd0);
        data_in = {12'($urandom), $urandom};
        step();
        chk("rst1_all", {out_valid, err, err_group, err_count, data_out}, 64'd0);
        rst = 1'b1; data_in = enc(32'hDEAD_BEEF);
        step();
        chk("rel_ov_early", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        step();
        chk_out("rel_first", 1'b1, 32'hDEAD_BEEF, 1'b0);
        in_valid = 1'b1; data_in = 44'h000_0000_0000;
        step();
        data_in = 44'h7FF_FFFF_FFFF;
        step();
        chk_out("rt0", 1'b1, 32'h0000_0000, 1'b0);
        data_in = enc(32'h1234_5678);
        step();
        chk_out("rt1", 1'b1, 32'hFFFF_FFFF, 1'b0);
        data_in = enc(32'hA5A5_5A5A);
        step();
        chk_out("rt2", 1'b1, 32'h1234_5678, 1'b0);
        in_valid = 1'b0;
        step();
        chk_out("rt3", 1'b1, 32'hA5A5_5A5A, 1'b0);
        step();
        chk_out("rt_end", 1'b0, 32'hA5A5_5A5A, 1'b0);
        chk("cnt_zero", {48'd0, err_count}, 64'd0);
        in_valid = 1'b1; data_in = BAD;
        step();
        in_valid = 1'b0;
        step();
        chk_out("inv", 1'b1, 32'h0, 1'b1);
        chk("inv_grp", {53'd0, err_group}, {53'd0, 11'b100_0000_1000});
        chk("inv_cnt", {48'd0, err_count}, 64'd1);
        in_valid = 1'b1; data_in = enc(32'h0000_1111);
        step();
        in_valid = 1'b0;
        step();
        chk_out("gap_a", 1'b1, 32'h0000_1111, 1'b0);
        chk("gap_a_grp", {53'd0, err_group}, 64'd0);
        in_valid = 1'b1; data_in = enc(32'h2222_3333);
        step();
        chk_out("gap_hold", 1'b0, 32'h0000_1111, 1'b0);
        in_valid = 1'b0;
        step();
        chk_out("gap_b", 1'b1, 32'h2222_3333, 1'b0);
        step();
        chk("gap_end_ov", {63'd0, out_valid}, 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr0", {48'd0, err_count}, 64'd0);
        in_valid = 1'b1; data_in = BAD;
        for (int i = 0; i < 65535; i++) step();
        chk("pre_fffe", {48'd0, err_count}, 64'hFFFE);
        in_valid = 1'b0;
        step();
        chk("pre_ffff", {48'd0, err_count}, 64'hFFFF);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("sat_hold", {48'd0, err_count}, 64'hFFFF);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_sat", {48'd0, err_count}, 64'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_out("clr_prio_out", 1'b1, 32'h0, 1'b1);
        chk("clr_prio", {48'd0, err_count}, 64'd0);
        step();
        chk("clr_prio_after", {48'd0, err_count}, 64'd0);
        in_valid = 1'b1; data_in = BAD;
        step();
        data_in = enc(32'h0BAD_F00D);
        step();
        chk("mid_cnt", {48'd0, err_count}, 64'd1);
        data_in = enc(32'h7777_7777); rst = 1'b0;
        step();
        chk("mid_rst_all", {out_valid, err, err_group, err_count, data_out}, 64'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_ov", {out_valid, err, err_group, err_count, data_out}, 64'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ftc_dec_top.md
# ftc_dec_top

Forbidden-transition-code (FTC) decoder for the 44-bit coded bus. It accepts eleven 4-bit FTC codewords produced by the FTC encoder stage and recovers the original 32-bit data word through a 2-stage registered pipeline. It checks every codeword against the codebook and reports invalid codewords per group, with a saturating error counter. It sits directly downstream of the encoder's registered 44-bit output, at the receive end of the coded interconnect.

## Interface
- No parameters. Widths are fixed: 44-bit coded input, 32-bit data output, 11 groups.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk)
- data_in  input  44  coded bus; group g occupies bits [4g+3:4g], g=0..10
- in_valid  input  1  data_in is a valid coded word this cycle
- err_clr  input  1  synchronous clear of err_count
- data_out  output  32  decoded word; group g drives bits [3g+2:3g], g=0..9; group 10 drives bits [31:30]
- out_valid  output  1  data_out, err and err_group are valid this cycle (single-cycle pulse per word)
- err  output  1  at least one group of this word held an invalid codeword
- err_group  output  11  per-group invalid flag; bit g set if group g is invalid
- err_count  output  16  number of words with err=1, saturating at 16'hFFFF

## Operation
- Codebook, 3-bit value to 4-bit codeword:
  - 000→0000, 001→0001, 010→0011, 011→0111
  - 100→1000, 101→1001, 110→1100, 111→1111
- Groups 0..9: any other codeword is invalid. An invalid group decodes to 000 and sets its err_group bit.
- Group 10 (top group): only 0000, 0001, 0011 and 0111 are valid, because the encoder drives msb=0 on this group. Decoded bits [1:0] go to data_out[31:30]. Codewords 1000, 1001, 1100 and 1111 are also flagged invalid in group 10, and all invalid group-10 codewords decode to 00.
- Stage 1: when in_valid=1, register data_in into a capture register and set s1_valid=1. When in_valid=0, set s1_valid=0 and hold the capture register.
- Stage 2: decode the capture register combinationally, then register data_out, err_group and err (the OR of all err_group bits). out_valid takes the value of s1_valid.
- When out_valid=0, data_out, err and err_group hold their last values.
- err_count:
  - Increments by 1 in the cycle stage 2 registers a word with err=1.
  - Holds at 16'hFFFF once reached.
  - err_clr=1 forces 0 on the next edge. err_clr has priority over a simultaneous increment, so that increment is lost.
- Back-to-back words with in_valid held high produce one result per cycle. No stalls and no backpressure.

## Timing
- Reset (rst=0 at an edge): data_out=0, err=0, err_group=0, out_valid=0, err_count=0, capture register=0, s1_valid=0.
- Reset in mid-operation discards in-flight words, and none of them appear on out_valid.
- First edge after rst returns high: the block samples in_valid normally.
- Latency is 2 clocks. A word presented with in_valid=1 before edge N appears with out_valid=1 after edge N+1.
- Throughput is 1 word per clock.
- err_count updates at the same edge at which the erroneous word's out_valid rises.

## Test plan
- Reset: drive rst=0 for 2 cycles with in_valid=1 and random data_in. All outputs must be 0 throughout; after release, the first out_valid appears 2 edges after the first sampled word.
- Round trip: stream data_in=44'h0000_0000_000 then 44'hF_FFFF_FFFF_FF with the top nibble 0111 (i.e. coded 32'hFFFF_FFFF), then the coded forms of 32'h1234_5678 and 32'hA5A5_5A5A on consecutive cycles. data_out must be 0, FFFF_FFFF, 1234_5678, A5A5_5A5A on consecutive cycles, with err=0 and out_valid high for 4 cycles.
- Invalid codeword: take coded 32'h0 and set group 3 to 0101 and group 10 to 1000. Required: err=1, err_group=11'b100_0000_1000, data_out=0, err_count=1.
- Gaps: toggle in_valid 1,0,1. out_valid must show 1,0,1 delayed by 2 cycles, and data_out must hold across the gap.
- Counter: preload via 65 535 error words, then send 2 more. err_count must stay at FFFF. Then assert err_clr in the same cycle as an error word's stage-2 edge: err_count must be 0 afterwards, not 1.
- Reset mid-stream: assert rst=0 while two words are in flight. Neither word may produce out_valid, and err_count must be 0.
